// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
// Each digit slot lasts SCAN_DIV cycles; the first cycle of every slot is a blanked
// anti-ghost gap. Digit, decimal-point and blink inputs go into shadow registers once
// per frame, so a frame never shows a mix of old and new values.
// Optional feature: define SEG_SCAN_BLINK_EN to build the blink counter and per-digit
// blinking. Without it, blink_mask is accepted but ignored.
// All outputs are decoded from registered state only.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);

  logic [CntW-1:0] cnt_q;
  logic [1:0]      idx_q;
  logic [15:0]     digits_sh_q;
  logic [3:0]      dp_sh_q;
  logic            blank_q;
  logic            cnt_wrap;
  logic            frame_end;
  logic            blink_off;

  assign cnt_wrap  = (cnt_q == CntW'(SCAN_DIV - 1));
  assign frame_end = cnt_wrap && (idx_q == 2'd3);

  // Slot timing: cnt runs through one digit slot, idx steps to the next digit on wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_wrap) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Blank is registered so that no input has a combinational path to the outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BlinkW-1:0] blink_cnt_q;
  logic              phase_q;
  logic [3:0]        blink_sh_q;

  // Free-running blink timebase; the phase toggles once per BLINK_DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Blink mask shadow, captured together with the other shadows at frame end.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_sh_q <= '0;
    end else if (frame_end) begin
      blink_sh_q <= blink_mask;
    end
  end

  assign blink_off = phase_q & blink_sh_q[idx_q];
`else
  logic unused_blink_mask;

  assign unused_blink_mask = ^blink_mask;
  assign blink_off         = 1'b0;
`endif

  // Digit and decimal-point shadows, loaded on the last cycle of the frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      digits_sh_q <= '0;
      dp_sh_q     <= '0;
    end else if (frame_end) begin
      digits_sh_q <= digits;
      dp_sh_q     <= dp_mask;
    end
  end

  // Active-low {g,f,e,d,c,b,a}; A..E are dark but keep the anode on, F is a dash.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hF:    s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Output decode: everything dark during the gap, blank, or a blinked-off slot.
  always_comb begin
    an  = 4'b1111;
    seg = 7'b1111111;
    dp  = 1'b1;
    if ((cnt_q != '0) && !blank_q && !blink_off) begin
      an  = ~(4'b0001 << idx_q);
      seg = decode(digits_sh_q[{idx_q, 2'b00} +: 4]);
      dp  = ~dp_sh_q[idx_q];
    end
  end

endmodule
